pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 clk  in  1  pipeline clock, all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 PC  in  32  current IF-stage PC from the PC register.
REQ-004 PC4  in  32  PC + 4 from the PC register.
REQ-005 Stall_Req  in  1  load-use hazard request from hazard unit.
REQ-006 Br_Taken_EX / Br_Target_EX  in  1/32  resolved taken branch in EX, plus its target.
REQ-007 Jump_ID / Jump_Target_ID  in  1/32  J/JAL/JR/JALR decoded in ID, plus its resolved target.
REQ-008 Eret_ID  in  1  ERET decoded in ID.
REQ-009 Irq  in  1  external interrupt, level; may be asynchronous to program flow but synchronous to clk.
REQ-010 PC_Next  out  32  next-PC value to the PC register.
REQ-011 Keep  out  1  hold PC register and IF/ID register.
REQ-012 Flush_IF_ID / Flush_ID_EX  out  1/1  squash the respective pipeline register.
REQ-013 EPC  out  32  exception return address.
REQ-014 Kernel  out  1  high while in handler.
REQ-015 Parameters: RESET_VEC default 32'h00400000, boot PC; HANDLER_VEC default 32'h80000004, interrupt entry; HOLDOFF default 2, cycles of interrupt mask after ERET.

Function
REQ-016 Next-PC priority, highest first: Br_Taken_EX > interrupt accept > Eret_ID > Jump_ID > Stall_Req > sequential.
REQ-017 Br_Taken_EX=1: PC_Next=Br_Target_EX, Keep=0, Flush_IF_ID=1, Flush_ID_EX=1; Stall_Req and every ID-stage request are ignored that cycle.
REQ-018 ID-stage requests (Eret_ID, Jump_ID) are honoured only when Stall_Req=0 and Br_Taken_EX=0; if honoured, Flush_IF_ID=1 and Keep=0.
REQ-019 Jump_ID: PC_Next=Jump_Target_ID.
REQ-020 Eret_ID: PC_Next=EPC; state KERNEL->HOLD.
REQ-021 Stall_Req only (no redirect): Keep=1, Flush_ID_EX=1 (bubble), Flush_IF_ID=0, PC_Next=PC4 (don't-care while held).
REQ-022 No request: PC_Next=PC4, Keep=0, both flushes 0.
REQ-023 Pending latch: set on any cycle Irq=1; cleared only on the accept cycle; Irq deasserting does not clear it.
REQ-024 Accept condition: pending=1, state USER, Stall_Req=0, Br_Taken_EX=0.
REQ-025 On accept: PC_Next=HANDLER_VEC, Flush_IF_ID=1, Keep=0.
REQ-026 On accept: EPC<=Jump_Target_ID if Jump_ID=1, else PC; the ID-stage redirect is discarded and Jump_ID is dropped that cycle.
REQ-027 On accept: Kernel<=1, state USER->KERNEL.
REQ-028 A taken EX branch coinciding with a pending interrupt wins; the interrupt is accepted on a later eligible cycle.
REQ-029 FSM states USER, KERNEL, HOLD.
REQ-030 HOLD: loads counter=HOLDOFF-1 and decrements each cycle; exits to USER when it reaches 0; pending cannot be accepted in HOLD.
REQ-031 Kernel=1 in KERNEL only; it clears on the ERET cycle edge.
REQ-032 Eret_ID outside KERNEL is treated as a plain jump to EPC with no state change.
REQ-033 Nested interrupts are not supported; pending stays set through KERNEL and HOLD.
REQ-034 EPC holds its value except on accept.

Reset
REQ-035 While rst=1: PC_Next=RESET_VEC, Keep=0, Flush_IF_ID=1, Flush_ID_EX=1, EPC=0, Kernel=0, pending=0, state USER, counter=0.
REQ-036 Reset mid-handler or mid-HOLD returns to USER immediately; pending interrupts are lost.

Structure
REQ-037 Shared CPU package holds the FSM state enum (USER/KERNEL/HOLD), RESET_VEC and HANDLER_VEC constants.
REQ-038 Single module with no sub-modules; the next-PC mux is combinational and the FSM, pending, EPC and counter are registered.

Verification
REQ-039 Sequential fetch: no requests for 3 cycles from PC=0x00400000 -> PC_Next 0x00400004, 0x00400008, 0x0040000C; Keep=0.
REQ-040 Stall_Req=1 and Jump_ID=1 together -> Keep=1, Flush_ID_EX=1, PC_Next not the jump target; next cycle Stall_Req=0 -> PC_Next=Jump_Target_ID, Flush_IF_ID=1.
REQ-041 Br_Taken_EX=1 (target 0x00400100) with Stall_Req=1 and Jump_ID=1 -> PC_Next=0x00400100, Keep=0, both flushes=1.
REQ-042 Irq pulsed 1 cycle while PC=0x00400020, no jump -> next eligible cycle PC_Next=0x80000004, Flush_IF_ID=1, then EPC=0x00400020, Kernel=1.
REQ-043 Eret_ID in KERNEL with Irq held high -> PC_Next=EPC, Kernel=0; interrupt re-accepted no earlier than 2 cycles after the ERET edge.
REQ-044 rst asserted while in KERNEL -> Kernel=0, EPC=0, PC_Next=0x00400000 asynchronously; pending Irq not taken after release unless Irq reasserts.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared CPU definitions for the next-PC sequencer
// Privilege state encoding and the architectural boot/interrupt vectors.
package pc_sequencer_pkg;

   typedef enum logic [1:0] {
      USER   = 2'd0,
      KERNEL = 2'd1,
      HOLD   = 2'd2
   } state_t;

   localparam logic [31:0] RESET_VEC   = 32'h0040_0000;
   localparam logic [31:0] HANDLER_VEC = 32'h8000_0004;

endpackage

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC selection, pipeline hold/flush and interrupt entry/return
// Combinational redirect mux; FSM, pending latch, EPC and holdoff counter are registered.
module pc_sequencer #(
   parameter logic [31:0] RESET_VEC   = pc_sequencer_pkg::RESET_VEC,
   parameter logic [31:0] HANDLER_VEC = pc_sequencer_pkg::HANDLER_VEC,
   parameter int unsigned HOLDOFF     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] PC,
   input  logic [31:0] PC4,
   input  logic        Stall_Req,
   input  logic        Br_Taken_EX,
   input  logic [31:0] Br_Target_EX,
   input  logic        Jump_ID,
   input  logic [31:0] Jump_Target_ID,
   input  logic        Eret_ID,
   input  logic        Irq,
   output logic [31:0] PC_Next,
   output logic        Keep,
   output logic        Flush_IF_ID,
   output logic        Flush_ID_EX,
   output logic [31:0] EPC,
   output logic        Kernel
);
   import pc_sequencer_pkg::*;

   localparam int unsigned CW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLDOFF - 1);

   state_t        r_state;
   logic          r_pending;
   logic [31:0]   r_epc;
   logic          r_kernel;
   logic [CW-1:0] r_cnt;

   logic w_accept;
   logic w_id_ok;
   logic w_eret;
   logic w_jump;

   // An accepted interrupt steals the cycle from any ID-stage redirect.
   assign w_accept = r_pending && (r_state == USER) && !Stall_Req && !Br_Taken_EX;
   assign w_id_ok  = !Stall_Req && !Br_Taken_EX && !w_accept;
   assign w_eret   = Eret_ID && w_id_ok;
   assign w_jump   = Jump_ID && w_id_ok && !Eret_ID;

   always_comb begin
      PC_Next     = PC4;
      Keep        = 1'b0;
      Flush_IF_ID = 1'b0;
      Flush_ID_EX = 1'b0;
      if (rst) begin
         PC_Next     = RESET_VEC;
         Flush_IF_ID = 1'b1;
         Flush_ID_EX = 1'b1;
      end else if (Br_Taken_EX) begin
         PC_Next     = Br_Target_EX;
         Flush_IF_ID = 1'b1;
         Flush_ID_EX = 1'b1;
      end else if (w_accept) begin
         PC_Next     = HANDLER_VEC;
         Flush_IF_ID = 1'b1;
      end else if (w_eret) begin
         PC_Next     = r_epc;
         Flush_IF_ID = 1'b1;
      end else if (w_jump) begin
         PC_Next     = Jump_Target_ID;
         Flush_IF_ID = 1'b1;
      end else if (Stall_Req) begin
         Keep        = 1'b1;
         Flush_ID_EX = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= USER;
         r_pending <= 1'b0;
         r_epc     <= '0;
         r_kernel  <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_pending <= w_accept ? 1'b0 : (r_pending | Irq);
         // A jump sitting in ID completes, so the handler returns to its target.
         if (w_accept)
            r_epc <= Jump_ID ? Jump_Target_ID : PC;
         case (r_state)
            USER: begin
               if (w_accept) begin
                  r_state  <= KERNEL;
                  r_kernel <= 1'b1;
               end
            end
            KERNEL: begin
               if (w_eret) begin
                  r_state  <= HOLD;
                  r_kernel <= 1'b0;
                  r_cnt    <= HOLD_LOAD;
               end
            end
            HOLD: begin
               if (r_cnt == '0)
                  r_state <= USER;
               else
                  r_cnt <= r_cnt - CW'(1);
            end
            default: begin
               r_state  <= USER;
               r_kernel <= 1'b0;
            end
         endcase
      end
   end

   assign EPC    = r_epc;
   assign Kernel = r_kernel;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
// Directed scenarios plus randomized traffic checked against a cycle-level reference model.
module tb_pc_sequencer;

   localparam logic [31:0] RV = 32'h0040_0000;
   localparam logic [31:0] HV = 32'h8000_0004;
   localparam int          HO = 2;

   logic        clk, rst;
   logic [31:0] PC, PC4, Br_Target_EX, Jump_Target_ID;
   logic        Stall_Req, Br_Taken_EX, Jump_ID, Eret_ID, Irq;
   logic [31:0] PC_Next, EPC;
   logic        Keep, Flush_IF_ID, Flush_ID_EX, Kernel;

   pc_sequencer #(.RESET_VEC(RV), .HANDLER_VEC(HV), .HOLDOFF(HO)) dut (
      .clk(clk), .rst(rst), .PC(PC), .PC4(PC4),
      .Stall_Req(Stall_Req), .Br_Taken_EX(Br_Taken_EX), .Br_Target_EX(Br_Target_EX),
      .Jump_ID(Jump_ID), .Jump_Target_ID(Jump_Target_ID), .Eret_ID(Eret_ID), .Irq(Irq),
      .PC_Next(PC_Next), .Keep(Keep), .Flush_IF_ID(Flush_IF_ID), .Flush_ID_EX(Flush_ID_EX),
      .EPC(EPC), .Kernel(Kernel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   // Reference model: privilege flag, remaining holdoff cycles, pending flag, saved EPC, fetch PC.
   bit          m_kernel, m_pend;
   int          m_hold;
   logic [31:0] m_epc, pc;
   logic [31:0] e_next;
   bit          e_keep, e_fi, e_fe, e_accept;

   task automatic model_reset();
      m_kernel = 0; m_pend = 0; m_hold = 0; m_epc = '0; pc = RV;
   endtask

   task automatic predict();
      bit user_mode;
      user_mode = !m_kernel && (m_hold == 0);
      e_accept = m_pend && user_mode && !Stall_Req && !Br_Taken_EX;
      e_keep = 0; e_fi = 0; e_fe = 0; e_next = pc + 32'd4;
      if (Br_Taken_EX) begin
         e_next = Br_Target_EX; e_fi = 1; e_fe = 1;
      end else if (e_accept) begin
         e_next = HV; e_fi = 1;
      end else if (Stall_Req) begin
         e_keep = 1; e_fe = 1;
      end else if (Eret_ID) begin
         e_next = m_epc; e_fi = 1;
      end else if (Jump_ID) begin
         e_next = Jump_Target_ID; e_fi = 1;
      end
   endtask

   task automatic commit();
      if (e_accept) begin
         m_epc = Jump_ID ? Jump_Target_ID : pc;
         m_kernel = 1;
      end else if (!Br_Taken_EX && !Stall_Req && Eret_ID && m_kernel) begin
         m_kernel = 0;
         m_hold = HO;
      end else if (m_hold > 0) begin
         m_hold--;
      end
      m_pend = e_accept ? 1'b0 : (m_pend | Irq);
      if (!e_keep) pc = e_next;
   endtask

   task automatic drive(input logic st, input logic br, input logic [31:0] bt,
                        input logic jp, input logic [31:0] jt, input logic er, input logic irq);
      Stall_Req = st; Br_Taken_EX = br; Br_Target_EX = bt;
      Jump_ID = jp; Jump_Target_ID = jt; Eret_ID = er; Irq = irq;
      PC = pc; PC4 = pc + 32'd4;
      predict();
      @(negedge clk);
   endtask

   task automatic advance();
      @(posedge clk);
      commit();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      Stall_Req = 0; Br_Taken_EX = 0; Br_Target_EX = '0; Jump_ID = 0;
      Jump_Target_ID = '0; Eret_ID = 0; Irq = 0; PC = '0; PC4 = 32'd4;
      model_reset();
      @(posedge clk); #1;
      n_total++;
      if (PC_Next !== RV || Keep !== 1'b0 || Flush_IF_ID !== 1'b1 || Flush_ID_EX !== 1'b1)
         $display("FAIL reset_mux: got next=%h keep=%b fi=%b fe=%b required next=%h keep=0 fi=1 fe=1",
                  PC_Next, Keep, Flush_IF_ID, Flush_ID_EX, RV);
      else n_pass++;
      n_total++;
      if (EPC !== 32'd0 || Kernel !== 1'b0)
         $display("FAIL reset_regs: got epc=%h kernel=%b required 0/0", EPC, Kernel);
      else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, '0, 0, '0, 0, 0);
         n_total++;
         if (PC_Next !== RV + 32'(4 * (i + 1)) || Keep !== 1'b0)
            $display("FAIL seq_fetch %0d: got next=%h keep=%b required next=%h keep=0",
                     i, PC_Next, Keep, RV + 32'(4 * (i + 1)));
         else n_pass++;
         advance();
      end
   endtask

   task automatic test_stall_jump();
      logic [31:0] jt;
      jt = 32'h0040_0200;
      drive(1, 0, '0, 1, jt, 0, 0);
      n_total++;
      if (Keep !== 1'b1 || Flush_ID_EX !== 1'b1 || Flush_IF_ID !== 1'b0 || PC_Next === jt)
         $display("FAIL stall_over_jump: got keep=%b fe=%b fi=%b next=%h required keep=1 fe=1 fi=0 next!=%h",
                  Keep, Flush_ID_EX, Flush_IF_ID, PC_Next, jt);
      else n_pass++;
      advance();
      drive(0, 0, '0, 1, jt, 0, 0);
      n_total++;
      if (PC_Next !== jt || Flush_IF_ID !== 1'b1 || Keep !== 1'b0)
         $display("FAIL jump_after_stall: got next=%h fi=%b keep=%b required next=%h fi=1 keep=0",
                  PC_Next, Flush_IF_ID, Keep, jt);
      else n_pass++;
      advance();
   endtask

   task automatic test_branch_priority();
      drive(1, 1, 32'h0040_0100, 1, 32'h0040_0300, 0, 0);
      n_total++;
      if (PC_Next !== 32'h0040_0100 || Keep !== 1'b0 || Flush_IF_ID !== 1'b1 || Flush_ID_EX !== 1'b1)
         $display("FAIL branch_wins: got next=%h keep=%b fi=%b fe=%b required next=00400100 keep=0 fi=1 fe=1",
                  PC_Next, Keep, Flush_IF_ID, Flush_ID_EX);
      else n_pass++;
      advance();
   endtask

   task automatic test_irq_accept();
      pc = 32'h0040_0020;
      // Irq pulse while the front end is stalled keeps PC parked at 0x00400020.
      drive(1, 0, '0, 0, '0, 0, 1);
      n_total++;
      if (PC_Next === HV)
         $display("FAIL irq_not_same_cycle: got next=%h required not %h", PC_Next, HV);
      else n_pass++;
      advance();
      drive(0, 0, '0, 0, '0, 0, 0);
      n_total++;
      if (PC_Next !== HV || Flush_IF_ID !== 1'b1 || Keep !== 1'b0)
         $display("FAIL irq_accept: got next=%h fi=%b keep=%b required next=%h fi=1 keep=0",
                  PC_Next, Flush_IF_ID, Keep, HV);
      else n_pass++;
      advance();
      drive(0, 0, '0, 0, '0, 0, 0);
      n_total++;
      if (EPC !== 32'h0040_0020 || Kernel !== 1'b1)
         $display("FAIL irq_entry_regs: got epc=%h kernel=%b required 00400020/1", EPC, Kernel);
      else n_pass++;
      advance();
   endtask

   task automatic test_eret_holdoff();
      int acc_at;
      drive(0, 0, '0, 0, '0, 1, 1);
      n_total++;
      if (PC_Next !== 32'h0040_0020 || Flush_IF_ID !== 1'b1)
         $display("FAIL eret_target: got next=%h fi=%b required 00400020/1", PC_Next, Flush_IF_ID);
      else n_pass++;
      advance();
      acc_at = -1;
      for (int i = 0; i < 6 && acc_at < 0; i++) begin
         drive(0, 0, '0, 0, '0, 0, 1);
         if (i == 0) begin
            n_total++;
            if (Kernel !== 1'b0)
               $display("FAIL eret_kernel_clear: got kernel=%b required 0", Kernel);
            else n_pass++;
         end
         if (PC_Next === HV) acc_at = i;
         advance();
      end
      n_total++;
      if (acc_at != HO)
         $display("FAIL holdoff_reaccept: got accept cycle %0d required %0d", acc_at, HO);
      else n_pass++;
   endtask

   task automatic test_reset_in_kernel();
      drive(0, 0, '0, 0, '0, 0, 1);
      advance();
      drive(0, 0, '0, 0, '0, 0, 0);
      n_total++;
      if (Kernel !== 1'b1)
         $display("FAIL kernel_before_reset: got kernel=%b required 1", Kernel);
      else n_pass++;
      #2 rst = 1'b1;
      #1;
      n_total++;
      if (Kernel !== 1'b0 || EPC !== 32'd0 || PC_Next !== RV)
         $display("FAIL async_reset: got kernel=%b epc=%h next=%h required 0/00000000/%h",
                  Kernel, EPC, PC_Next, RV);
      else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, '0, 0, '0, 0, 0);
         n_total++;
         if (PC_Next !== RV + 32'(4 * (i + 1)) || Kernel !== 1'b0)
            $display("FAIL pending_lost %0d: got next=%h kernel=%b required %h/0",
                     i, PC_Next, Kernel, RV + 32'(4 * (i + 1)));
         else n_pass++;
         advance();
      end
   endtask

   task automatic test_random();
      logic st, br, jp, er, irq;
      for (int c = 0; c < 400; c++) begin
         st  = ($urandom_range(0, 99) < 20);
         br  = ($urandom_range(0, 99) < 10);
         jp  = ($urandom_range(0, 99) < 25);
         er  = ($urandom_range(0, 99) < 15);
         irq = ($urandom_range(0, 99) < 8);
         drive(st, br, $urandom & 32'hFFFF_FFFC, jp, $urandom & 32'hFFFF_FFFC, er, irq);
         n_total++;
         if (PC_Next !== e_next)
            $display("FAIL rand_next c%0d: got %h required %h", c, PC_Next, e_next);
         else n_pass++;
         n_total++;
         if ({Keep, Flush_IF_ID, Flush_ID_EX} !== {e_keep, e_fi, e_fe})
            $display("FAIL rand_ctrl c%0d: got keep/fi/fe=%b%b%b required %b%b%b",
                     c, Keep, Flush_IF_ID, Flush_ID_EX, e_keep, e_fi, e_fe);
         else n_pass++;
         n_total++;
         if (EPC !== m_epc || Kernel !== m_kernel)
            $display("FAIL rand_regs c%0d: got epc=%h kernel=%b required %h/%b",
                     c, EPC, Kernel, m_epc, m_kernel);
         else n_pass++;
         advance();
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall_jump();
      test_branch_priority();
      test_irq_accept();
      test_eret_holdoff();
      test_reset_in_kernel();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
